// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit word MSB first, reps+1 times back to back.
// Optional even-parity bit after each word when PATTERN_TX_PARITY_EN is defined.
module pattern_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [2:0]       reps,
    output logic             x,
    output logic             busy,
    output logic             done
);

`ifdef PATTERN_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [4:0] PAR_POS = 5'(WIDTH - 1);
`else
    localparam int P = 0;
`endif
    // Index of the last bit of a word on x (data bits plus optional parity).
    localparam logic [4:0] LAST = 5'(WIDTH - 1 + P);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] sr;
    logic [2:0]       reps_q;
    logic [2:0]       repcnt;
    logic [4:0]       bitcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            word   <= '0;
            sr     <= '0;
            reps_q <= '0;
            repcnt <= '0;
            bitcnt <= '0;
            x      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    x    <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        word   <= pattern;
                        reps_q <= reps;
                        x      <= pattern[WIDTH-1];
                        sr     <= {pattern[WIDTH-2:0], 1'b0};
                        bitcnt <= '0;
                        repcnt <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // bitcnt tracks the bit currently on x; sr holds the bits still to come.
                    if (bitcnt == LAST) begin
                        if (repcnt == reps_q) begin
                            x     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            repcnt <= repcnt + 3'd1;
                            bitcnt <= '0;
                            x      <= word[WIDTH-1];
                            sr     <= {word[WIDTH-2:0], 1'b0};
                        end
                    end
`ifdef PATTERN_TX_PARITY_EN
                    else if (bitcnt == PAR_POS) begin
                        x      <= ^word;
                        bitcnt <= bitcnt + 5'd1;
                    end
`endif
                    else begin
                        x      <= sr[WIDTH-1];
                        sr     <= {sr[WIDTH-2:0], 1'b0};
                        bitcnt <= bitcnt + 5'd1;
                    end
                end
                DONE: begin
                    x     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    x     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: expected serial bits queued at stimulus time,
// popped and compared each cycle while the DUT transmits.
module tb_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [2:0] reps;
    logic       x;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    pattern_tx #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .x       (x),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_x"}, x, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    task automatic push_word(input logic [3:0] w, input logic [2:0] r);
        for (int unsigned k = 0; k <= 32'(r); k++) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PATTERN_TX_PARITY_EN
            exp_q.push_back(^w);
`endif
        end
    endtask

    // Full transmission; optionally disturbs start/pattern/reps mid-stream.
    task automatic tx(input logic [3:0] pat, input logic [2:0] r, input bit meddle);
        int n;
        logic e;
        @(negedge clk);
        pattern = pat;
        reps    = r;
        start   = 1'b1;
        push_word(pat, r);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            if (meddle && n == 2) begin
                start   = 1'b1;
                pattern = 4'b0110;
                reps    = 3'd7;
            end
            e = exp_q.pop_front();
            check("x_bit", x, e);
            check("busy_bit", busy, 1'b1);
            check("done_early", done, 1'b0);
            n++;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_x", x, 1'b0);
        @(negedge clk);
        check_idle("post_done");
        @(negedge clk);
        check_idle("idle_after");
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b1;
        pattern = 4'b1111;
        reps    = 3'd0;
        // Reset with start held: start must be ignored.
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_idle("release");

        tx(4'b1010, 3'd0, 1'b0);
        tx(4'b1010, 3'd1, 1'b0);
        tx(4'b1011, 3'd1, 1'b0);
        tx(4'b1100, 3'd2, 1'b1);

        // Reset mid-word on the third bit of a reps=2 transmission.
        @(negedge clk);
        pattern = 4'b1100;
        reps    = 3'd2;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_b0", x, 1'b1);
        @(negedge clk);
        check("rst_b1", x, 1'b1);
        @(negedge clk);
        check("rst_b2", x, 1'b0);
        check("rst_b2_busy", busy, 1'b1);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check_idle("no_resume");
        end

        tx(4'b0111, 3'd0, 1'b0);
        tx(4'b1001, 3'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
